mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 37 +++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: request op encoding, FSM states,
// and small decode helpers used by the top and the lane aligner.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension and
// read-modify-write merge of a byte or halfword into the fetched word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane ignores addr_lo[0], which aligns odd addresses down.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        load_data  = '0;
        store_word = rdata;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            OP_LW:   load_data = rdata;
            OP_SB:   store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            OP_SH:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a combinational-read data_memory (IDLE/RD/WR/RESP).
// Optional MISALIGN_TRAP_EN: misaligned accesses respond with resp_err and no strobe.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] readData
);

    state_e      state, state_next;
    op_e         op_q;
    op_e         req_op_e;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] result_q;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        accept;
    logic        trap;

    assign req_op_e = op_e'(req_op);
    assign accept   = (state == ST_IDLE) && req_valid;

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    assign trap     = is_misaligned(req_op_e, req_addr[1:0]);
    assign resp_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= trap;
    end
`else
    assign trap     = 1'b0;
    assign resp_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (trap)
                        state_next = ST_RESP;
                    else if (req_op_e == OP_SW)
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD:   state_next = is_store(op_q) ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // word_q holds the store word: full data for SW, the merged word for SB/SH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= req_op_e;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[15:0];
            word_q   <= req_wdata;
            result_q <= '0;
        end else if (state == ST_RD) begin
            if (is_store(op_q))
                word_q <= store_word;
            else
                result_q <= load_data;
        end
    end

    mem_lane_align u_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (readData),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = result_q;
    assign MemRead    = (state == ST_RD);
    assign MemWrite   = (state == ST_WR);
    assign address    = (MemRead || MemWrite) ? {addr_q[31:2], 2'b00} : '0;
    assign writeData  = MemWrite ? word_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word memory model.
// Expectations follow MISALIGN_TRAP_EN when the bench is built with it defined.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] readData;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

    int checks = 0;
    int failures = 0;

    wire unused_addr_hi = &{1'b0, address[31:8], address[1:0]};

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .writeData  (writeData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .readData   (readData)
    );

    always #5 clk = ~clk;

    assign readData = mem[address[7:2]];

    always @(posedge clk) begin
        if (MemWrite)
            mem[address[7:2]] <= writeData;
        else if (pl_en)
            mem[pl_idx] <= pl_data;
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if (MemRead) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= address;
        end
        if (MemWrite) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= address;
            last_wr_data <= writeData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycle 1 is the first negedge after the accept edge.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        issue(op, addr, wdata);
        wait_resp(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        ack();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, lat;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_wdata", writeData, 32'h0);
        rst_n = 1'b1;

        // SW: single write strobe, 2-cycle latency
        wr0 = wr_cnt; rd0 = rd_cnt;
        run("sw", OP_SW, 32'h10, 32'd10, 2, 32'h0, 1'b0);
        check("sw_wr_cnt", wr_cnt - wr0, 32'd1);
        check("sw_rd_cnt", rd_cnt - rd0, 32'd0);
        check("sw_wr_addr", last_wr_addr, 32'h10);
        check("sw_wr_data", last_wr_data, 32'd10);

        // Loads with extension
        preload(6'd8, 32'h8081F2F3);
        run("lb21", OP_LB, 32'h21, 32'h0, 2, 32'hFFFFFFF2, 1'b0);
        check("lb21_rd_addr", last_rd_addr, 32'h20);
        run("lbu21", OP_LBU, 32'h21, 32'h0, 2, 32'h000000F2, 1'b0);
        run("lh22", OP_LH, 32'h22, 32'h0, 2, 32'hFFFF8081, 1'b0);
        run("lhu22", OP_LHU, 32'h22, 32'h0, 2, 32'h00008081, 1'b0);
        run("lb23", OP_LB, 32'h23, 32'h0, 2, 32'hFFFFFF80, 1'b0);
        run("lbu20", OP_LBU, 32'h20, 32'h0, 2, 32'h000000F3, 1'b0);
        run("lw20", OP_LW, 32'h20, 32'h0, 2, 32'h8081F2F3, 1'b0);

        // Read-modify-write stores
        preload(6'd8, 32'h11223344);
        wr0 = wr_cnt; rd0 = rd_cnt;
        run("sb22", OP_SB, 32'h22, 32'hFFFFFFAA, 3, 32'h0, 1'b0);
        check("sb22_rd_cnt", rd_cnt - rd0, 32'd1);
        check("sb22_wr_cnt", wr_cnt - wr0, 32'd1);
        check("sb22_wr_addr", last_wr_addr, 32'h20);
        check("sb22_wr_data", last_wr_data, 32'h11AA3344);
        preload(6'd9, 32'h11223344);
        run("sh26", OP_SH, 32'h26, 32'h0000BEEF, 3, 32'h0, 1'b0);
        check("sh26_wr_data", last_wr_data, 32'hBEEF3344);
        run("lw24", OP_LW, 32'h24, 32'h0, 2, 32'hBEEF3344, 1'b0);

        // Backpressure: response held, new request ignored
        preload(6'd15, 32'h00000077);
        wr0 = wr_cnt;
        issue(OP_LW, 32'h24, 32'h0);
        wait_resp(lat);
        check("hold_lat", lat, 32'd2);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h3C; req_wdata = 32'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
            check("hold_resp_rdata", resp_rdata, 32'hBEEF3344);
            check("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_hs_resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        check("post_hs_no_write", wr_cnt - wr0, 32'd0);
        run("lw3c", OP_LW, 32'h3C, 32'h0, 2, 32'h00000077, 1'b0);

        // Reset during the WR cycle of an SH
        preload(6'd10, 32'hCAFEF00D);
        issue(OP_SH, 32'h28, 32'h00001234);
        @(negedge clk);
        check("shrst_rd", {31'h0, MemRead}, 32'h1);
        @(negedge clk);
        check("shrst_wr", {31'h0, MemWrite}, 32'h1);
        check("shrst_wdata", writeData, 32'hCAFE1234);
        #1 rst_n = 1'b0;
        #1;
        check("shrst_wr_drop", {31'h0, MemWrite}, 32'h0);
        check("shrst_rd_drop", {31'h0, MemRead}, 32'h0);
        check("shrst_idle", {31'h0, req_ready}, 32'h1);
        check("shrst_addr", address, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("shrst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        run("lw28", OP_LW, 32'h28, 32'h0, 2, 32'hCAFEF00D, 1'b0);

        // Misaligned accesses
        rd0 = rd_cnt;
`ifdef MISALIGN_TRAP_EN
        run("lw13", OP_LW, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        run("lh23", OP_LH, 32'h23, 32'h0, 1, 32'h0, 1'b1);
        check("mis_no_read", rd_cnt - rd0, 32'd0);
`else
        run("lw13", OP_LW, 32'h13, 32'h0, 2, 32'd10, 1'b0);
        check("lw13_rd_addr", last_rd_addr, 32'h10);
        run("lh23", OP_LH, 32'h23, 32'h0, 2, 32'h000011AA, 1'b0);
        check("mis_reads", rd_cnt - rd0, 32'd2);
`endif

        check("dual_strobe", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
